adder_share_arbiter: RTL
========================

# adder_share_arbiter

Round-robin arbiter and sequencer that shares one external 5-bit ripple adder (`fiveBitAdder`-class datapath) among several game-logic requesters, such as the head-X step, the head-Y step and the score increment. It captures one requester's operands, drives them onto the shared adder, registers the result and returns it with a per-requester valid pulse. It sits between the snake control logic and the single adder instance.

## Interface
- `NREQ`, 3, number of requesters; legal range 2..4
- `W`, 5, operand and result width

- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  NREQ  request per requester; held high until its `gnt`
- `req_a`  in  NREQ*W  operand A per requester; slice i = bits [i*W +: W]
- `req_b`  in  NREQ*W  operand B per requester; same packing
- `req_cin`  in  NREQ  carry-in per requester (1 with inverted B = subtract)
- `gnt`  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: `rsp_sum`/`rsp_cout` valid for that requester
- `rsp_sum`  out  W  registered sum
- `rsp_cout`  out  1  registered carry-out
- `add_a`  out  W  to shared adder A
- `add_b`  out  W  to shared adder B
- `add_cin`  out  1  to shared adder carry-in
- `add_sum`  in  W  from shared adder, combinational
- `add_cout`  in  1  from shared adder carry-out

## Operation
- FSM states: IDLE, ISSUE, RESP.
- Arbitration happens only in IDLE and RESP.
  - Round-robin search starts at index `last+1` mod NREQ.
  - `last` is the index of the most recent grant; its reset value is NREQ-1, so requester 0 has priority first.
- IDLE:
  - If any `req` is high, latch the winner index and its `req_a`, `req_b` and `req_cin` into operand registers.
  - Set `gnt[winner]` (registered), update `last`, go to ISSUE.
  - If no `req` is high, stay in IDLE.
- ISSUE:
  - `add_a`, `add_b` and `add_cin` come from the operand registers.
  - `gnt` is high for this cycle only.
  - At the closing edge, capture `add_sum` into `rsp_sum` and `add_cout` into `rsp_cout`, set `rsp_valid[idx]`, go to RESP.
  - `req` is ignored in this state.
- RESP:
  - `rsp_valid[idx]` is high for this cycle only.
  - The same arbitration as IDLE runs: with any `req` high, go to ISSUE with the new winner; otherwise go to IDLE.
- Requester handshake:
  - Deassert `req` in the cycle `gnt` is seen, unless another operation is wanted.
  - A `req` still high in RESP is eligible again, but round-robin order puts the other pending requesters ahead of it.
- Operands must be stable whenever the matching `req` is high.
- Outside ISSUE, `add_a`, `add_b` and `add_cin` are driven to 0.
- `rsp_sum` and `rsp_cout` hold their last value between responses.
- Arithmetic:
  - `rsp_sum` = (A + B + cin) mod 2^W.
  - `rsp_cout` = bit W of the full sum.
  - Wrap-around is silent; the requester interprets `rsp_cout`.
  - Subtraction: the requester supplies ~B with cin = 1. `rsp_cout` = 1 means no borrow.
- Simultaneous requests: exactly one grant per arbitration cycle; no requester starves.
  - With all NREQ held high, grants rotate 0,1,..,NREQ-1,0.

## Timing
- Reset (async, immediate): state IDLE, `last` = NREQ-1.
  - `gnt`, `rsp_valid`, `rsp_sum`, `rsp_cout`, `add_a`, `add_b`, `add_cin`: all 0.
- Reset mid-operation (ISSUE or RESP): the operation is dropped with no `rsp_valid`. The requester must re-request after reset deasserts.
- Latency: `req` sampled at edge 0 → `gnt` in cycle 1 (ISSUE) → `rsp_valid` in cycle 2.
- Throughput: one operation per 2 cycles with back-to-back requests (RESP→ISSUE); 3 cycles when passing through IDLE.
- `add_sum` must settle within one clock period of `add_*` changing; the shared adder is purely combinational.
- `gnt` and `rsp_valid` are never high in the same cycle. Each is at most one-hot.

## Test plan
- After reset, `req`=001 with A=3, B=4, cin=1 → `gnt`=001 in cycle 1 with `add_a`=3, `add_b`=4, `add_cin`=1; `rsp_valid`=001 in cycle 2 with `rsp_sum`=8, `rsp_cout`=0.
- Wrap and subtract:
  - req1 with A=31, B=1, cin=0 → `rsp_sum`=0, `rsp_cout`=1.
  - req2 with A=5, B=29 (~2), cin=1 → `rsp_sum`=3, `rsp_cout`=1.
- `req`=111 held continuously → `gnt` sequence 001, 010, 100, 001 at cycles 1, 3, 5, 7; each `rsp_valid` follows its `gnt` by one cycle with the matching sums.
- Assert `rst` during ISSUE for requester 1 → all outputs 0 immediately, no `rsp_valid`. After release with `req`=011, the first `gnt` is 001.
- No requests for 10 cycles → `gnt`=0, `rsp_valid`=0, `add_a`/`add_b`/`add_cin`=0, `rsp_sum` holds its previous value.
- req0 held high, then req2 raised at its first `gnt` cycle → grants 001, 100, 001, alternating; no second consecutive grant to req0 while req2 waits.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares one external combinational W-bit adder among NREQ requesters.
//   A round-robin arbiter picks one pending requester, latches its operands,
//   presents them to the shared adder for one cycle (ISSUE), registers the
//   result and returns it with a one-hot valid pulse (RESP).
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-requester request, held until its gnt
//   req_a/b    per-requester operands, slice i = [i*W +: W]
//   req_cin    per-requester carry-in
//   gnt        one-hot, one-cycle pulse: operands captured (high during ISSUE)
//   rsp_valid  one-hot, one-cycle pulse: rsp_sum/rsp_cout valid (high during RESP)
//   rsp_sum    registered sum, holds between responses
//   rsp_cout   registered carry-out, holds between responses
//   add_a/b    to shared adder, 0 outside ISSUE
//   add_cin    to shared adder, 0 outside ISSUE
//   add_sum    from shared adder (combinational)
//   add_cout   from shared adder (combinational)
module adder_share_arbiter #(
    parameter int NREQ = 3,
    parameter int W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   last_reg;
    logic [IW-1:0]   idx_reg;
    logic [W-1:0]    op_a_reg, op_b_reg;
    logic            op_cin_reg;
    logic [NREQ-1:0] gnt_reg, rsp_valid_reg;
    logic [W-1:0]    rsp_sum_reg;
    logic            rsp_cout_reg;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            arb_enable;
    logic            take;

    // Round-robin search starting at last+1. The loop walks from the
    // farthest candidate towards the nearest so the nearest pending
    // requester is the final assignment and wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_reg) + k) % NREQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // req is only looked at in IDLE and RESP; ISSUE ignores it.
    assign arb_enable = (state_reg == IDLE) || (state_reg == RESP);
    assign take       = arb_enable && win_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_found) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = win_found ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg      <= IW'(NREQ - 1);
            idx_reg       <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_cin_reg    <= 1'b0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
        end else begin
            // Both pulses default low so each lasts exactly one cycle.
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            if (take) begin
                idx_reg          <= win_idx;
                last_reg         <= win_idx;
                op_a_reg         <= req_a[int'(win_idx)*W +: W];
                op_b_reg         <= req_b[int'(win_idx)*W +: W];
                op_cin_reg       <= req_cin[win_idx];
                gnt_reg[win_idx] <= 1'b1;
            end
            // The adder has had the whole ISSUE cycle to settle.
            if (state_reg == ISSUE) begin
                rsp_sum_reg            <= add_sum;
                rsp_cout_reg           <= add_cout;
                rsp_valid_reg[idx_reg] <= 1'b1;
            end
        end
    end

    assign gnt       = gnt_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;

    // Adder inputs are gated so the shared adder sees zeros when idle.
    assign add_a   = (state_reg == ISSUE) ? op_a_reg   : '0;
    assign add_b   = (state_reg == ISSUE) ? op_b_reg   : '0;
    assign add_cin = (state_reg == ISSUE) ? op_cin_reg : 1'b0;

endmodule
